// File: rtl/rexecute_pkg.sv
// rexecute_pkg: shared types, opcodes and mul/div state encodings for the execute stage
package rexecute_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  typedef enum logic [1:0] {MD_IDLE, MD_LOAD, MD_ITER, MD_DONE} md_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_branch;
    logic            is_jump;
    logic            is_muldiv;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] rd_data;
    logic            regfile_load;
  } cword_t;
endpackage

// File: rtl/rexecute_muldiv.sv
// rexecute_muldiv: iterative RV32M unit, shift-add multiply and restoring divide on magnitudes
module rexecute_muldiv
  import rexecute_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] result
);
  md_state_t state;
  logic [4:0] cnt;
  logic [63:0] acc, nxt, prod;
  logic [31:0] dvs, q, r;
  logic [32:0] rs, msum;
  logic [2:0] f3;
  logic sa, sb, bz, na, nb, ge;
  always_comb begin
    na = a[31] & (funct3[2] ? ~funct3[0] : funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    nb = b[31] & (funct3[2] ? ~funct3[0] : funct3[1:0] == 2'b01);
    msum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, dvs} : 33'd0);
    rs = {acc[63:32], acc[31]};
    ge = rs >= {1'b0, dvs};
    nxt = f3[2] ? {ge ? 32'(rs - {1'b0, dvs}) : rs[31:0], acc[30:0], ge} : {msum, acc[31:1]};
    prod = (sa ^ sb) ? -acc : acc;
    q = bz ? '1 : (sa ^ sb) ? -acc[31:0] : acc[31:0];
    r = sa ? -acc[63:32] : acc[63:32];
    result = f3[2] ? (f3[1] ? r : q) : (f3[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
    busy = state == MD_LOAD || state == MD_ITER || (state == MD_IDLE && start && !stall);
  end
  // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt <= '0;
      acc <= '0;
      dvs <= '0;
      f3 <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      bz <= 1'b0;
    end else if (!stall) begin
      case (state)
        MD_IDLE: if (start) state <= MD_LOAD;
        MD_LOAD: begin
          acc <= {32'd0, na ? -a : a};
          dvs <= nb ? -b : b;
          f3 <= funct3;
          sa <= na;
          sb <= nb;
          bz <= b == '0;
          cnt <= '0;
          state <= MD_ITER;
        end
        MD_ITER: begin
          acc <= nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= MD_DONE;
        end
        MD_DONE: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/rexecute.sv
// rexecute: execute stage with inline ALU/branch resolution and an iterative mul/div unit
module rexecute
  import rexecute_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  cword_t          rf_ex_cword,
  output cword_t          ex_mem_cword,
  output logic            ex_busy,
  output logic            ex_redirect,
  output logic [XLEN-1:0] ex_redirect_pc
);
  cword_t c, nxt;
  logic [XLEN-1:0] opb, alu, sra, res, target, md_result;
  logic [4:0] sh;
  logic cond, taken, md_busy;
  assign c = rf_ex_cword;
  always_comb begin
    opb = c.use_imm ? c.imm : c.rs2_data;
    sh = opb[4:0];
    sra = $signed(c.rs1_data) >>> sh;
    alu = '0;
    case (c.funct3)
      3'd0: alu = (c.opcode == OP_REG && c.funct7[5]) ? c.rs1_data - opb : c.rs1_data + opb;
      3'd1: alu = c.rs1_data << sh;
      3'd2: alu = {31'd0, $signed(c.rs1_data) < $signed(opb)};
      3'd3: alu = {31'd0, c.rs1_data < opb};
      3'd4: alu = c.rs1_data ^ opb;
      3'd5: alu = c.funct7[5] ? sra : c.rs1_data >> sh;
      3'd6: alu = c.rs1_data | opb;
      3'd7: alu = c.rs1_data & opb;
    endcase
    cond = c.funct3[2] ? ((c.funct3[1] ? c.rs1_data < c.rs2_data
                                       : $signed(c.rs1_data) < $signed(c.rs2_data)) ^ c.funct3[0])
                       : (!c.funct3[1] && ((c.rs1_data == c.rs2_data) ^ c.funct3[0]));
    taken = (c.is_branch & cond) | c.is_jump;
    target = c.opcode == OP_JALR ? (c.rs1_data + c.imm) & ~32'd1 : c.pc + c.imm;
    res = c.is_muldiv ? md_result :
          c.opcode == OP_LUI ? c.imm :
          c.opcode == OP_AUIPC ? c.pc + c.imm :
          (c.opcode == OP_LOAD || c.opcode == OP_STORE) ? c.rs1_data + c.imm :
          (c.opcode == OP_JAL || c.opcode == OP_JALR) ? c.pc + 32'd4 :
          (c.opcode == OP_IMM || c.opcode == OP_REG) ? alu : '0;
    nxt = c;
    nxt.rd_data = res;
    nxt.regfile_load = c.regfile_load & (MULDIV_EN | ~c.is_muldiv);
  end
  generate
    if (MULDIV_EN) begin : g_md
      rexecute_muldiv u_md (
        .clk(clk), .rst_n(rst_n), .stall(stall), .start(c.is_muldiv), .funct3(c.funct3),
        .a(c.rs1_data), .b(c.rs2_data), .busy(md_busy), .result(md_result)
      );
    end else begin : g_nomd
      assign md_busy = 1'b0;
      assign md_result = '0;
    end
  endgenerate
  assign ex_busy = md_busy;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_mem_cword <= '0;
      ex_redirect <= 1'b0;
      ex_redirect_pc <= '0;
    end else if (!stall && !ex_busy) begin
      ex_mem_cword <= nxt;
      ex_redirect <= taken;
      ex_redirect_pc <= taken ? target : '0;
    end
  end
endmodule

// File: tb/tb_rexecute.sv
// tb_rexecute: directed and randomized checks of rexecute against an arithmetic reference model
module tb_rexecute;
  import rexecute_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  cword_t rf = '0, ex_mem_cword;
  logic ex_busy, ex_redirect;
  logic [31:0] ex_redirect_pc;
  int tests = 0, fails = 0;
  logic [31:0] last_rd = '0;
  logic [6:0] ops [9] = '{OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
  logic [6:0] rop, rf7;
  logic [2:0] rf3;
  logic rui;

  rexecute dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .rf_ex_cword(rf),
    .ex_mem_cword(ex_mem_cword), .ex_busy(ex_busy), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cword_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic ui, input logic [31:0] pc);
    cword_t w = '0;
    w.opcode = op; w.funct3 = f3; w.funct7 = f7; w.rs1_data = a; w.rs2_data = b;
    w.imm = imm; w.use_imm = ui; w.pc = pc; w.rd = 5'd7;
    w.is_branch = op == OP_BRANCH;
    w.is_jump = op == OP_JAL || op == OP_JALR;
    w.is_muldiv = op == OP_REG && f7 == 7'd1;
    w.regfile_load = !(w.is_branch || op == OP_STORE);
    return w;
  endfunction

  function automatic logic [31:0] model_rd(input cword_t w);
    logic [31:0] a, b;
    int sh;
    longint p;
    longint unsigned pu;
    logic ovf;
    a = w.rs1_data;
    b = w.use_imm ? w.imm : w.rs2_data;
    sh = int'(b[4:0]);
    if (w.is_muldiv) begin
      b = w.rs2_data;
      ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
      case (w.funct3)
        3'd0: return a * b;
        3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
        3'd2: begin p = longint'($signed(a)) * longint'(b); return p[63:32]; end
        3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
        3'd4: return b == 0 ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
        3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
        3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
        default: return b == 0 ? a : a % b;
      endcase
    end
    case (w.opcode)
      OP_LUI: return w.imm;
      OP_AUIPC: return w.pc + w.imm;
      OP_LOAD, OP_STORE: return a + w.imm;
      OP_JAL, OP_JALR: return w.pc + 32'd4;
      OP_IMM, OP_REG: case (w.funct3)
        3'd0: return (w.opcode == OP_REG && w.funct7[5]) ? a - b : a + b;
        3'd1: return a << sh;
        3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return w.funct7[5] ? (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0) : a >> sh;
        3'd6: return a | b;
        default: return a & b;
      endcase
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(input cword_t w);
    if (w.opcode == OP_JAL || w.opcode == OP_JALR) return 1'b1;
    if (w.opcode != OP_BRANCH) return 1'b0;
    case (w.funct3)
      3'd0: return w.rs1_data == w.rs2_data;
      3'd1: return w.rs1_data != w.rs2_data;
      3'd4: return $signed(w.rs1_data) < $signed(w.rs2_data);
      3'd5: return $signed(w.rs1_data) >= $signed(w.rs2_data);
      3'd6: return w.rs1_data < w.rs2_data;
      3'd7: return w.rs1_data >= w.rs2_data;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input cword_t w);
    return w.opcode == OP_JALR ? (w.rs1_data + w.imm) & 32'hFFFFFFFE : w.pc + w.imm;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  task automatic run_op(input string tag, input cword_t w);
    logic t;
    t = model_taken(w);
    rf = w;
    step();
    chk({tag, "_rd"}, ex_mem_cword.rd_data, model_rd(w));
    chk({tag, "_ld"}, 32'(ex_mem_cword.regfile_load), 32'(w.regfile_load));
    chk({tag, "_redir"}, 32'(ex_redirect), 32'(t));
    if (t) chk({tag, "_pc"}, ex_redirect_pc, model_target(w));
    last_rd = model_rd(w);
    rf = '0;
  endtask

  task automatic run_md(input string tag, input cword_t w, input int ist, input int dst);
    int n;
    n = 0;
    rf = w;
    #1;
    while (ex_busy === 1'b1 && n < 200) begin
      stall = n >= 10 && n < 10 + ist;
      step();
      n++;
    end
    stall = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(34 + ist));
    chk({tag, "_hold"}, ex_mem_cword.rd_data, last_rd);
    if (dst > 0) begin
      stall = 1'b1;
      repeat (dst) step();
      chk({tag, "_done_busy"}, 32'(ex_busy), 32'd0);
      chk({tag, "_done_hold"}, ex_mem_cword.rd_data, last_rd);
      stall = 1'b0;
    end
    step();
    chk({tag, "_rd"}, ex_mem_cword.rd_data, model_rd(w));
    chk({tag, "_ld"}, 32'(ex_mem_cword.regfile_load), 32'(w.regfile_load));
    last_rd = model_rd(w);
    rf = '0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_cword", 32'(|ex_mem_cword), 32'd0);
    chk("rst_redir", 32'(ex_redirect), 32'd0);
    chk("rst_pc", ex_redirect_pc, 32'd0);
    chk("rst_busy", 32'(ex_busy), 32'd0);
    rst_n = 1'b1;
    run_op("add", mk(OP_REG, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 1'b0, 32'h0));
    chk("add_lit", ex_mem_cword.rd_data, 32'd12);
    run_op("sub", mk(OP_REG, 3'd0, 7'h20, 32'd0, 32'd1, 32'd0, 1'b0, 32'h0));
    chk("sub_lit", ex_mem_cword.rd_data, 32'hFFFFFFFF);
    run_op("sra", mk(OP_REG, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'd0, 1'b0, 32'h0));
    chk("sra_lit", ex_mem_cword.rd_data, 32'hF8000000);
    run_op("sltu", mk(OP_REG, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0));
    run_op("bne", mk(OP_BRANCH, 3'd1, 7'h00, 32'd3, 32'd4, 32'h20, 1'b0, 32'h100));
    chk("bne_pc_lit", ex_redirect_pc, 32'h120);
    stall = 1'b1;
    rf = mk(OP_REG, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 1'b0, 32'h0);
    step();
    chk("redir_held", 32'(ex_redirect), 32'd1);
    chk("stall_hold", ex_mem_cword.rd_data, last_rd);
    stall = 1'b0;
    run_op("bubble", '0);
    run_op("beq", mk(OP_BRANCH, 3'd0, 7'h00, 32'd3, 32'd4, 32'h20, 1'b0, 32'h100));
    run_op("jalr", mk(OP_JALR, 3'd0, 7'h00, 32'h201, 32'd0, 32'd0, 1'b1, 32'h300));
    chk("jalr_pc_lit", ex_redirect_pc, 32'h200);
    run_md("mulhu", mk(OP_REG, 3'd3, 7'h01, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 32'h0), 0, 0);
    chk("mulhu_lit", ex_mem_cword.rd_data, 32'd1);
    run_md("mulh", mk(OP_REG, 3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0), 0, 0);
    run_md("mul", mk(OP_REG, 3'd0, 7'h01, 32'h10000, 32'h10000, 32'd0, 1'b0, 32'h0), 0, 0);
    run_md("div0", mk(OP_REG, 3'd4, 7'h01, 32'd7, 32'd0, 32'd0, 1'b0, 32'h0), 0, 0);
    run_md("remu0", mk(OP_REG, 3'd7, 7'h01, 32'd7, 32'd0, 32'd0, 1'b0, 32'h0), 0, 0);
    run_md("div_ovf", mk(OP_REG, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0), 0, 0);
    run_md("rem_neg", mk(OP_REG, 3'd6, 7'h01, -32'd7, 32'd2, 32'd0, 1'b0, 32'h0), 0, 0);
    chk("rem_neg_lit", ex_mem_cword.rd_data, 32'hFFFFFFFF);
    run_md("div_neg", mk(OP_REG, 3'd4, 7'h01, -32'd7, 32'd2, 32'd0, 1'b0, 32'h0), 0, 0);
    chk("div_neg_lit", ex_mem_cword.rd_data, -32'd3);
    run_md("div_stall", mk(OP_REG, 3'd4, 7'h01, 32'd100, 32'd7, 32'd0, 1'b0, 32'h0), 5, 5);
    rf = mk(OP_REG, 3'd0, 7'h01, 32'h1234, 32'h5678, 32'd0, 1'b0, 32'h0);
    repeat (12) step();
    chk("rst_mid_busy", 32'(ex_busy), 32'd1);
    rst_n = 1'b0;
    rf = '0;
    step();
    chk("rst_mid_idle", 32'(ex_busy), 32'd0);
    chk("rst_mid_cword", 32'(|ex_mem_cword), 32'd0);
    rst_n = 1'b1;
    last_rd = '0;
    run_op("add_after_rst", mk(OP_REG, 3'd0, 7'h00, 32'd40, 32'd2, 32'd0, 1'b0, 32'h0));
    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 8)];
      rf3 = 3'($urandom());
      rf7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      rui = rop != OP_REG && rop != OP_BRANCH;
      run_op("rand_alu", mk(rop, rf3, rf7, pick(), pick(), $urandom(), rui, $urandom() & 32'hFFFFFFFC));
    end
    for (int i = 0; i < 16; i++) begin
      rf3 = 3'($urandom());
      run_md("rand_md", mk(OP_REG, rf3, 7'h01, pick(), pick(), 32'd0, 1'b0, 32'h0), 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
